sig_gen_sequencer: RTL

//  Sequences read_bram_control for the signal generator: turns a start/trigger request into N

---
 rtl/sig_gen_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/sig_gen_sequencer.sv
// sig_gen_sequencer
// Sequences read_bram_control for the signal generator. A start request (optionally
// gated by an external trigger edge) produces n_bursts single-pass BRAM playbacks,
// each preceded by a one-cycle read-pointer restart (PRELOAD) and separated by
// gap_cycles idle cycles. n_bursts = 0 repeats until stop.
//
// Ports
//   axi_clock, rst_n         clock (rising edge) and asynchronous active-low reset
//   start, stop              sequence request / abort (stop wins over everything)
//   trig_mode, trig_each     wait for ext_trig rising edge before first / every burst
//   ext_trig                 external trigger level
//   n_bursts, gap_cycles     bursts per sequence, idle cycles between bursts
//   dec_rate_in, default_in  playback settings, latched at start
//   finish_read              end-of-burst indication from read_bram_control
//   rst_read, en_read        read_bram_control pointer restart / playback enable
//   continous                tied low, repetition is handled here
//   dec_rate, default_value  latched playback settings
//   busy, armed              not IDLE / waiting for trigger
//   burst_cnt                completed bursts this sequence (saturating)
//   done                     one-cycle pulse on normal completion
//
// Build option
//   EXT_TRIG_SYNC_EN  adds a 2-flop synchronizer on ext_trig (trigger latency 4
//                     cycles instead of 2).

module sig_gen_sequencer #(
   parameter int CNT_WIDTH = 16,
   parameter int GAP_WIDTH = 32
) (
   input  logic                 axi_clock,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 trig_mode,
   input  logic                 trig_each,
   input  logic                 ext_trig,
   input  logic [CNT_WIDTH-1:0] n_bursts,
   input  logic [GAP_WIDTH-1:0] gap_cycles,
   input  logic [31:0]          dec_rate_in,
   input  logic [31:0]          default_in,
   input  logic                 finish_read,
   output logic                 rst_read,
   output logic                 en_read,
   output logic                 continous,
   output logic [31:0]          dec_rate,
   output logic [31:0]          default_value,
   output logic                 busy,
   output logic                 armed,
   output logic [CNT_WIDTH-1:0] burst_cnt,
   output logic                 done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_PRELOAD,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [CNT_WIDTH-1:0] n_bursts_q, n_bursts_d;
   logic [GAP_WIDTH-1:0] gap_q, gap_d;
   logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic                 trig_each_q, trig_each_d;
   logic [31:0]          dec_rate_q, dec_rate_d;
   logic [31:0]          default_value_q, default_value_d;
   logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
   logic                 rst_read_q, rst_read_d;
   logic                 en_read_q, en_read_d;
   logic                 busy_q, busy_d;
   logic                 armed_q, armed_d;
   logic                 done_q, done_d;

   logic                 trig_src;
   logic                 trig_q0, trig_q1;
   logic                 trig_edge;
   logic [CNT_WIDTH-1:0] burst_inc;
   state_t               rearm_state;

`ifdef EXT_TRIG_SYNC_EN
   logic sync_q0, sync_q1;

   // ext_trig is asynchronous in this build, so it passes two flops first
   always_ff @(posedge axi_clock or negedge rst_n) begin
      if (!rst_n) begin
         sync_q0 <= 1'b0;
         sync_q1 <= 1'b0;
      end else begin
         sync_q0 <= ext_trig;
         sync_q1 <= sync_q0;
      end
   end

   assign trig_src = sync_q1;
`else
   assign trig_src = ext_trig;
`endif

   // Edge detector taps run continuously, so a level already high when ARM is
   // entered never looks like an edge
   always_ff @(posedge axi_clock or negedge rst_n) begin
      if (!rst_n) begin
         trig_q0 <= 1'b0;
         trig_q1 <= 1'b0;
      end else begin
         trig_q0 <= trig_src;
         trig_q1 <= trig_q0;
      end
   end

   assign trig_edge = trig_q0 & ~trig_q1;

   // State, latched configuration and registered outputs
   always_ff @(posedge axi_clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         n_bursts_q      <= '0;
         gap_q           <= '0;
         gap_cnt_q       <= '0;
         trig_each_q     <= 1'b0;
         dec_rate_q      <= '0;
         default_value_q <= '0;
         burst_cnt_q     <= '0;
         rst_read_q      <= 1'b1;
         en_read_q       <= 1'b0;
         busy_q          <= 1'b0;
         armed_q         <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         n_bursts_q      <= n_bursts_d;
         gap_q           <= gap_d;
         gap_cnt_q       <= gap_cnt_d;
         trig_each_q     <= trig_each_d;
         dec_rate_q      <= dec_rate_d;
         default_value_q <= default_value_d;
         burst_cnt_q     <= burst_cnt_d;
         rst_read_q      <= rst_read_d;
         en_read_q       <= en_read_d;
         busy_q          <= busy_d;
         armed_q         <= armed_d;
         done_q          <= done_d;
      end
   end

   // Next-state logic. Outputs are decoded from the next state so the registered
   // outputs always describe the state the sequencer is currently in.
   always_comb begin
      state_d         = state_q;
      n_bursts_d      = n_bursts_q;
      gap_d           = gap_q;
      gap_cnt_d       = gap_cnt_q;
      trig_each_d     = trig_each_q;
      dec_rate_d      = dec_rate_q;
      default_value_d = default_value_q;
      burst_cnt_d     = burst_cnt_q;
      burst_inc       = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + CNT_WIDTH'(1);
      rearm_state     = trig_each_q ? S_ARM : S_PRELOAD;

      if (stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  n_bursts_d      = n_bursts;
                  gap_d           = gap_cycles;
                  // per-burst re-arm only makes sense in triggered mode
                  trig_each_d     = trig_each & trig_mode;
                  dec_rate_d      = dec_rate_in;
                  default_value_d = default_in;
                  burst_cnt_d     = '0;
                  state_d         = trig_mode ? S_ARM : S_PRELOAD;
               end
            end
            S_ARM: begin
               if (trig_edge) begin
                  state_d = S_PRELOAD;
               end
            end
            S_PRELOAD: begin
               state_d = S_PLAY;
            end
            S_PLAY: begin
               if (finish_read) begin
                  burst_cnt_d = burst_inc;
                  if ((n_bursts_q != '0) && (burst_inc == n_bursts_q)) begin
                     state_d = S_DONE;
                  end else if (gap_q != '0) begin
                     gap_cnt_d = gap_q - GAP_WIDTH'(1);
                     state_d   = S_GAP;
                  end else begin
                     state_d = rearm_state;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt_q == '0) begin
                  state_d = rearm_state;
               end else begin
                  gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      rst_read_d = (state_d == S_IDLE) || (state_d == S_PRELOAD);
      en_read_d  = (state_d == S_PLAY);
      busy_d     = (state_d != S_IDLE);
      armed_d    = (state_d == S_ARM);
      done_d     = (state_d == S_DONE);
   end

   assign rst_read      = rst_read_q;
   assign en_read       = en_read_q;
   assign continous     = 1'b0;
   assign dec_rate      = dec_rate_q;
   assign default_value = default_value_q;
   assign busy          = busy_q;
   assign armed         = armed_q;
   assign burst_cnt     = burst_cnt_q;
   assign done          = done_q;

endmodule
